async_fifo_write_ctrl: RTL and testbench

Write-side controller of the dual-clock FIFO. It sits in the write clock domain and turns write requests into a memory write enable and a write address. It also produces the Gray-coded write pointer that the read domain synchronises. Full is computed against the read pointer after that pointer has been synchronised into the write domain.

---
 rtl/async_fifo_write_ctrl_pkg.sv | 37 +++
 rtl/async_fifo_write_ctrl_if.sv | 33 +++
 rtl/async_fifo_write_ctrl_gray_ptr_counter.sv | 44 ++++
 rtl/async_fifo_write_ctrl.sv | 93 +++++++++
 tb/tb_async_fifo_write_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/async_fifo_write_ctrl_pkg.sv
// ============================================================================
// Module      : async_fifo_write_ctrl_pkg
// Description : Shared Gray-code helpers and defaults for the dual-clock FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package async_fifo_write_ctrl_pkg;

  localparam int C_DEFAULT_ADDR_SIZE = 8;

  function automatic logic [31:0] width_mask(input int width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int width);
    return ((bin >> 1) ^ bin) & width_mask(width);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
    logic [31:0] g;
    logic [31:0] b;
    g = gray & width_mask(width);
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // Pointer value that means "one full lap ahead" of the given Gray pointer.
  function automatic logic [31:0] gray_full_target(input logic [31:0] gray, input int width);
    return (gray ^ (32'd3 << (width - 2))) & width_mask(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/async_fifo_write_ctrl_if.sv
// ============================================================================
// Module      : async_fifo_write_ctrl_if
// Description : Producer/controller signal bundle for the FIFO write side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface async_fifo_write_ctrl_if
  import async_fifo_write_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = C_DEFAULT_ADDR_SIZE
);
  logic                 w_inc_i;
  logic [ADDR_SIZE:0]   w_r_ptr_i;
  logic                 w_en_o;
  logic [ADDR_SIZE-1:0] w_addr_o;
  logic [ADDR_SIZE:0]   w_ptr_o;
  logic                 w_full_o;
  logic                 w_ovf_o;
  logic                 w_almost_full_o;

  modport master (
    output w_inc_i, w_r_ptr_i,
    input  w_en_o, w_addr_o, w_ptr_o, w_full_o, w_ovf_o, w_almost_full_o
  );

  modport slave (
    input  w_inc_i, w_r_ptr_i,
    output w_en_o, w_addr_o, w_ptr_o, w_full_o, w_ovf_o, w_almost_full_o
  );
endinterface

`default_nettype wire

// File: rtl/async_fifo_write_ctrl_gray_ptr_counter.sv
// ============================================================================
// Module      : gray_ptr_counter
// Description : Binary + Gray pointer pair with enable; shared by both FIFO sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_ptr_counter
  import async_fifo_write_ctrl_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_ADDR_SIZE + 1
) (
  input  wire logic             w_clk_i,
  input  wire logic             w_rst_i,
  input  wire logic             i_en,
  output logic      [WIDTH-1:0] o_bin,
  output logic      [WIDTH-1:0] o_gray,
  output logic      [WIDTH-1:0] o_bin_next,
  output logic      [WIDTH-1:0] o_gray_next
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;

  assign o_bin_next  = r_bin + WIDTH'(i_en);
  assign o_gray_next = WIDTH'(bin2gray(32'(o_bin_next), WIDTH));

  // Gray is kept in its own flops so the crossing pointer never glitches.
  always_ff @(posedge w_clk_i or negedge w_rst_i) begin
    if (!w_rst_i) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= o_bin_next;
      r_gray <= o_gray_next;
    end
  end

  assign o_bin  = r_bin;
  assign o_gray = r_gray;

endmodule

`default_nettype wire

// File: rtl/async_fifo_write_ctrl.sv
// ============================================================================
// Module      : async_fifo_write_ctrl
// Description : Write-domain FIFO controller: address, Gray pointer, full/overflow.
//               Optional almost-full flag: define ASYNC_FIFO_ALMOST_FULL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_fifo_write_ctrl
  import async_fifo_write_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = C_DEFAULT_ADDR_SIZE,
  parameter int AF_MARGIN = 4
) (
  input wire logic               w_clk_i,
  input wire logic               w_rst_i,
  async_fifo_write_ctrl_if.slave bus
);

  localparam int C_PTR_W = ADDR_SIZE + 1;

  logic               r_full;
  logic               r_ovf;
  logic               w_accept;
  logic               w_full_next;
  logic [C_PTR_W-1:0] w_bin;
  logic [C_PTR_W-1:0] w_gray;
  logic [C_PTR_W-1:0] w_bin_next;
  logic [C_PTR_W-1:0] w_gray_next;

  assign w_accept = bus.w_inc_i & ~r_full;

  gray_ptr_counter #(
    .WIDTH       (C_PTR_W)
  ) u_ptr (
    .w_clk_i     (w_clk_i),
    .w_rst_i     (w_rst_i),
    .i_en        (w_accept),
    .o_bin       (w_bin),
    .o_gray      (w_gray),
    .o_bin_next  (w_bin_next),
    .o_gray_next (w_gray_next)
  );

  assign w_full_next = (w_gray_next == C_PTR_W'(gray_full_target(32'(bus.w_r_ptr_i), C_PTR_W)));

  always_ff @(posedge w_clk_i or negedge w_rst_i) begin
    if (!w_rst_i) begin
      r_full <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_full <= w_full_next;
      r_ovf  <= r_ovf | (bus.w_inc_i & r_full);
    end
  end

  assign bus.w_en_o   = w_accept;
  assign bus.w_addr_o = w_bin[ADDR_SIZE-1:0];
  assign bus.w_ptr_o  = w_gray;
  assign bus.w_full_o = r_full;
  assign bus.w_ovf_o  = r_ovf;

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  localparam logic [C_PTR_W-1:0] C_AF_THRESH = C_PTR_W'((1 << ADDR_SIZE) - AF_MARGIN);

  logic               r_almost_full;
  logic [C_PTR_W-1:0] w_rd_bin;
  logic [C_PTR_W-1:0] w_level;
  logic               w_unused;

  assign w_rd_bin = C_PTR_W'(gray2bin(32'(bus.w_r_ptr_i), C_PTR_W));
  assign w_level  = w_bin_next - w_rd_bin;
  assign w_unused = w_bin[ADDR_SIZE];

  always_ff @(posedge w_clk_i or negedge w_rst_i) begin
    if (!w_rst_i) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_level >= C_AF_THRESH);
    end
  end

  assign bus.w_almost_full_o = r_almost_full;
`else
  logic w_unused;

  assign w_unused = ^{w_bin[ADDR_SIZE], w_bin_next, (AF_MARGIN != 0)};
  assign bus.w_almost_full_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_write_ctrl.sv
// ============================================================================
// Module      : tb_async_fifo_write_ctrl
// Description : Directed self-checking bench for async_fifo_write_ctrl (depth 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_fifo_write_ctrl;

  localparam int ADDR_SIZE = 3;
  localparam int AF_MARGIN = 2;
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  localparam bit C_AF_EN = 1'b1;
`else
  localparam bit C_AF_EN = 1'b0;
`endif

  logic w_clk_i = 1'b0;
  logic w_rst_i = 1'b0;

  async_fifo_write_ctrl_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

  async_fifo_write_ctrl #(
    .ADDR_SIZE (ADDR_SIZE),
    .AF_MARGIN (AF_MARGIN)
  ) u_dut (
    .w_clk_i   (w_clk_i),
    .w_rst_i   (w_rst_i),
    .bus       (bus)
  );

  always #5 w_clk_i = ~w_clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk_i);
    #1;
  endtask

  function automatic logic [3:0] gray4(input int n);
    logic [3:0] m;
    m = 4'(n & 15);
    return m ^ (m >> 1);
  endfunction

  function automatic logic [31:0] af_exp(input bit level_hit);
    return 32'(level_hit & C_AF_EN);
  endfunction

  logic [3:0] r_prev;

  initial begin
    bus.w_inc_i   = 1'b0;
    bus.w_r_ptr_i = 4'b0000;
    tick();
    tick();
    check("rst_ptr",  32'(bus.w_ptr_o),         32'h0);
    check("rst_addr", 32'(bus.w_addr_o),        32'h0);
    check("rst_full", 32'(bus.w_full_o),        32'h0);
    check("rst_ovf",  32'(bus.w_ovf_o),         32'h0);
    check("rst_af",   32'(bus.w_almost_full_o), 32'h0);
    w_rst_i = 1'b1;

    // Fill eight slots against a stationary read pointer.
    for (int i = 0; i < 8; i++) begin
      bus.w_inc_i = 1'b1;
      #1;
      check("fill_en",   32'(bus.w_en_o),   32'h1);
      check("fill_addr", 32'(bus.w_addr_o), 32'(i));
      tick();
      check("fill_full", 32'(bus.w_full_o),        32'(i == 7));
      check("fill_af",   32'(bus.w_almost_full_o), af_exp(i >= 5));
    end
    check("fill_addr_wrap", 32'(bus.w_addr_o), 32'h0);
    check("fill_ptr",       32'(bus.w_ptr_o),  32'hC);

    // Write while full.
    #1;
    check("ovf_en", 32'(bus.w_en_o), 32'h0);
    tick();
    check("ovf_ptr",  32'(bus.w_ptr_o),  32'hC);
    check("ovf_flag", 32'(bus.w_ovf_o),  32'h1);
    check("ovf_full", 32'(bus.w_full_o), 32'h1);
    check("ovf_af",   32'(bus.w_almost_full_o), af_exp(1'b1));
    bus.w_inc_i = 1'b0;
    tick();
    check("ovf_sticky", 32'(bus.w_ovf_o), 32'h1);

    // Reader frees one slot.
    bus.w_r_ptr_i = 4'b0001;
    tick();
    check("rel_full", 32'(bus.w_full_o), 32'h0);
    bus.w_inc_i = 1'b1;
    #1;
    check("rel_en", 32'(bus.w_en_o), 32'h1);
    tick();
    check("rel_refull", 32'(bus.w_full_o), 32'h1);
    check("rel_ptr",    32'(bus.w_ptr_o),  32'hD);
    check("rel_addr",   32'(bus.w_addr_o), 32'h1);
    bus.w_inc_i = 1'b0;

    // Reader trails two behind; pointer runs through the 15 -> 0 wrap.
    bus.w_r_ptr_i = gray4(7);
    tick();
    check("wrap_unfull", 32'(bus.w_full_o), 32'h0);
    r_prev = bus.w_ptr_o;
    for (int k = 0; k < 20; k++) begin
      bus.w_r_ptr_i = gray4(9 + k - 2);
      bus.w_inc_i   = 1'b1;
      tick();
      check("wrap_ptr",    32'(bus.w_ptr_o),  32'(gray4(9 + k + 1)));
      check("wrap_full",   32'(bus.w_full_o), 32'h0);
      check("wrap_af",     32'(bus.w_almost_full_o), 32'h0);
      check("wrap_onebit", 32'($countones(r_prev ^ bus.w_ptr_o)), 32'h1);
      if (((9 + k + 1) % 16) == 0) begin
        check("wrap_prev8", 32'(r_prev),       32'h8);
        check("wrap_zero",  32'(bus.w_ptr_o),  32'h0);
      end
      r_prev = bus.w_ptr_o;
    end
    check("wrap_addr", 32'(bus.w_addr_o), 32'h5);

    // Asynchronous reset in the middle of a burst.
    #2;
    w_rst_i = 1'b0;
    #1;
    check("arst_ptr",  32'(bus.w_ptr_o),         32'h0);
    check("arst_addr", 32'(bus.w_addr_o),        32'h0);
    check("arst_full", 32'(bus.w_full_o),        32'h0);
    check("arst_ovf",  32'(bus.w_ovf_o),         32'h0);
    check("arst_af",   32'(bus.w_almost_full_o), 32'h0);
    tick();
    check("arst_hold", 32'(bus.w_ptr_o), 32'h0);
    bus.w_inc_i   = 1'b0;
    bus.w_r_ptr_i = 4'b0000;
    w_rst_i = 1'b1;

    // Almost-full threshold of six entries.
    for (int i = 0; i < 6; i++) begin
      bus.w_inc_i = 1'b1;
      tick();
      check("af_step", 32'(bus.w_almost_full_o), af_exp(i == 5));
    end
    bus.w_inc_i = 1'b0;
    tick();
    check("af_hold", 32'(bus.w_almost_full_o), af_exp(1'b1));
    check("af_addr", 32'(bus.w_addr_o),        32'h6);
    w_rst_i = 1'b0;
    #1;
    check("af_rst", 32'(bus.w_almost_full_o), 32'h0);
    w_rst_i = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
